// File: rtl/circular_dma_pkg.sv
// Shared helpers for the circular DMA capture path: burst sizing, the stored-word
// layout and elaboration-time parameter sanity rules.
package circular_dma_pkg;

  localparam int unsigned C_IDLE_WIDTH = 32;

  function automatic int unsigned burst_bytes(input int unsigned data_width,
                                              input int unsigned max_burst);
    return (data_width / 8) * max_burst;
  endfunction

  // Stored word is {tlast, tdata}.
  function automatic int unsigned word_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

  function automatic bit params_ok(input int unsigned data_width,
                                   input int unsigned depth,
                                   input int unsigned max_burst,
                                   input int unsigned occ_width);
    return ((data_width % 8) == 0) &&
           (depth >= 2 * max_burst) &&
           ((depth & (depth - 1)) == 0) &&
           (occ_width > $clog2(depth));
  endfunction

endpackage

// File: rtl/counter_big.sv
// Wide free-running counter with synchronous clear and count enable.
module counter_big #(
  parameter int C_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  output logic [C_WIDTH-1:0] count_o
);

  logic [C_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + C_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/circular_dma_fifo.sv
// FWFT buffer in front of the circular DMA write FSM: block-RAM FIFO whose registered
// read port is the output register, exact occupancy export and flush-level generation.
module circular_dma_fifo
  import circular_dma_pkg::*;
#(
  parameter int C_AXIS_WIDTH       = 64,
  parameter int C_DEPTH            = 256,
  parameter int C_MAX_BURST        = 16,
  parameter int C_AXIS_OCCUP_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_AXIS_WIDTH-1:0]       s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [C_AXIS_WIDTH-1:0]       m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_OCCUP_WIDTH-1:0] fifo_occupancy,
  output logic                          flush_fifo,
  input  logic                          flush_req,
  input  logic [31:0]                   flush_timeout,
  output logic [31:0]                   overflow_count
);

  localparam int WORD_W = word_width(C_AXIS_WIDTH);
  localparam int PTR_W  = $clog2(C_DEPTH);
  localparam int OW     = C_AXIS_OCCUP_WIDTH;
  localparam logic [OW-1:0] OCC_FULL = OW'(C_DEPTH);

  generate
    if (!params_ok(C_AXIS_WIDTH, C_DEPTH, C_MAX_BURST, C_AXIS_OCCUP_WIDTH)) begin : g_bad_params
      $fatal(1, "circular_dma_fifo: illegal parameter combination");
    end
  endgenerate

  logic [WORD_W-1:0] mem [C_DEPTH];
  logic [WORD_W-1:0] dout_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d, ram_cnt_q, ram_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              s_ready_q, s_ready_d;
  logic              flush_q, flush_d;
  logic [31:0]       ovf_q, ovf_d;
  logic [C_IDLE_WIDTH-1:0] idle_count;
  logic              wr_en, rd_en, load_en, idle_rst, idle_en;

  // Outputs are forced low while rst is asserted so nothing glitches in the reset cycle.
  assign s_axis_tready  = s_ready_q & ~rst;
  assign m_axis_tvalid  = out_valid_q & ~rst;
  assign m_axis_tdata   = rst ? '0 : dout_q[C_AXIS_WIDTH-1:0];
  assign m_axis_tlast   = dout_q[C_AXIS_WIDTH] & ~rst;
  assign fifo_occupancy = rst ? '0 : occ_q;
  assign flush_fifo     = flush_q & ~rst;
  assign overflow_count = rst ? '0 : ovf_q;

  assign wr_en   = s_axis_tvalid & s_axis_tready;
  assign rd_en   = m_axis_tvalid & m_axis_tready;
  // The RAM read register doubles as the FWFT stage: reload whenever it is empty or drained.
  assign load_en = (ram_cnt_q != '0) && (!out_valid_q || m_axis_tready);

  assign idle_rst = rst | wr_en;
  assign idle_en  = ~&idle_count;

  counter_big #(.C_WIDTH(C_IDLE_WIDTH)) u_idle_counter (
    .clk     (clk),
    .rst     (idle_rst),
    .en_i    (idle_en),
    .count_o (idle_count)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d    = rd_ptr_q + PTR_W'(load_en);
    ram_cnt_d   = ram_cnt_q + OW'(wr_en) - OW'(load_en);
    occ_d       = occ_q + OW'(wr_en) - OW'(rd_en);
    out_valid_d = load_en | (out_valid_q & ~rd_en);
    s_ready_d   = (occ_d != OCC_FULL);
    ovf_d       = ovf_q;
    if (s_axis_tvalid && (occ_q == OCC_FULL) && (ovf_q != '1)) ovf_d = ovf_q + 32'd1;
    flush_d     = flush_q;
    if (occ_q == '0)
      flush_d = 1'b0;
    else if (flush_req || ((flush_timeout != 32'd0) && (idle_count >= flush_timeout)))
      flush_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      s_ready_q   <= 1'b1;
      flush_q     <= 1'b0;
      ovf_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      s_ready_q   <= s_ready_d;
      flush_q     <= flush_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst)          dout_q <= '0;
    else if (load_en) dout_q <= mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_circular_dma_fifo.sv
// Directed self-checking bench for circular_dma_fifo (default parameters, depth 256).
module tb_circular_dma_fifo;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [15:0]   fifo_occupancy;
  logic          flush_fifo;
  logic          flush_req;
  logic [31:0]   flush_timeout;
  logic [31:0]   overflow_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  circular_dma_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .fifo_occupancy (fifo_occupancy),
    .flush_fifo     (flush_fifo),
    .flush_req      (flush_req),
    .flush_timeout  (flush_timeout),
    .overflow_count (overflow_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic l);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
  endtask

  function automatic logic [W-1:0] stream_word(input int n);
    logic [31:0] hi;
    hi = 32'(n) * 32'h9E3779B1;
    return {hi, 32'(n)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 64'hDEAD_BEEF_0000_0001;
    s_axis_tlast = 1'b1; m_axis_tready = 1'b0; flush_req = 1'b0; flush_timeout = 32'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, flush_fifo} !== 4'b0 ||
          fifo_occupancy !== 16'd0 || overflow_count !== 32'd0 || m_axis_tdata !== 64'd0) begin
        fails++;
        $display("FAIL reset_outputs cyc%0d: tready=%b tvalid=%b occ=%0d flush=%b ovf=%0d data=%h, required all 0",
                 c, s_axis_tready, m_axis_tvalid, fifo_occupancy, flush_fifo, overflow_count, m_axis_tdata);
      end
    end
    rst = 1'b0; s_axis_tvalid = 1'b0;
    #1;
    tests++;
    if (s_axis_tready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_after: got %b, required 1", s_axis_tready);
    end
    tests++;
    if (fifo_occupancy !== 16'd0) begin
      fails++; $display("FAIL reset_occ_after: got %0d, required 0", fifo_occupancy);
    end
    step();
    tests++;
    if (m_axis_tvalid !== 1'b0) begin
      fails++; $display("FAIL reset_tvalid_after: got %b, required 0", m_axis_tvalid);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_fill_full();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tests++;
      if (s_axis_tready !== 1'b1) begin
        fails++; $display("FAIL fill_ready word %0d: got %b, required 1", i, s_axis_tready);
      end
      push(64'hF1F0_0000_0000_0000 + 64'(i), (i % 8) == 7);
    end
    s_axis_tvalid = 1'b1; s_axis_tdata = 64'hBAD0_BAD0_BAD0_BAD0; s_axis_tlast = 1'b0;
    tests++;
    if (fifo_occupancy !== 16'd256) begin
      fails++; $display("FAIL full_occ: got %0d, required 256", fifo_occupancy);
    end
    tests++;
    if (s_axis_tready !== 1'b0) begin
      fails++; $display("FAIL full_ready: got %b, required 0", s_axis_tready);
    end
    repeat (4) step();
    s_axis_tvalid = 1'b0;
    tests++;
    if (overflow_count !== 32'd4) begin
      fails++; $display("FAIL overflow_count: got %0d, required 4", overflow_count);
    end
    tests++;
    if (fifo_occupancy !== 16'd256) begin
      fails++; $display("FAIL full_occ_hold: got %0d, required 256", fifo_occupancy);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tests++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hF1F0_0000_0000_0000 + 64'(i) ||
          m_axis_tlast !== ((i % 8) == 7)) begin
        fails++;
        $display("FAIL drain word %0d: valid=%b data=%h last=%b, required 1 %h %b", i,
                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, 64'hF1F0_0000_0000_0000 + 64'(i), (i % 8) == 7);
      end
      step();
    end
    m_axis_tready = 1'b0;
    tests++;
    if (fifo_occupancy !== 16'd0 || m_axis_tvalid !== 1'b0) begin
      fails++; $display("FAIL drain_empty: occ=%0d valid=%b, required 0 0", fifo_occupancy, m_axis_tvalid);
    end
    $display("[TB] fill_full: overflow=%0d", overflow_count);
  endtask

  task automatic test_streaming();
    logic [W:0] q[$];
    logic [W:0] exp;
    int tx = 0;
    int rx = 0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 1200 && rx < 1000; c++) begin
      s_axis_tvalid = (tx < 1000);
      s_axis_tdata  = stream_word(tx);
      s_axis_tlast  = (tx % 16) == 15;
      #1;
      if (c >= 2 && c <= 1000) begin
        tests++;
        if (m_axis_tvalid !== 1'b1 || fifo_occupancy !== 16'd2) begin
          fails++;
          $display("FAIL stream_steady cyc%0d: valid=%b occ=%0d, required 1 2", c, m_axis_tvalid, fifo_occupancy);
        end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL stream_unexpected word: got %h, required none", m_axis_tdata);
        end else begin
          exp = q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== exp) begin
            fails++; $display("FAIL stream_data #%0d: got %h, required %h", rx, {m_axis_tlast, m_axis_tdata}, exp);
          end
        end
        rx++;
      end
      if (s_axis_tvalid === 1'b1 && s_axis_tready === 1'b1) begin
        q.push_back({s_axis_tlast, s_axis_tdata});
        tx++;
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    tests++;
    if (rx != 1000 || fifo_occupancy !== 16'd0) begin
      fails++; $display("FAIL stream_total: received=%0d occ=%0d, required 1000 0", rx, fifo_occupancy);
    end
    $display("[TB] streaming: sent=%0d received=%0d", tx, rx);
  endtask

  task automatic test_timeout_flush();
    int k;
    int n;
    flush_timeout = 32'd100;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) push(64'h7100 + 64'(i), i == 4);
    tests++;
    if (flush_fifo !== 1'b0 || fifo_occupancy !== 16'd5) begin
      fails++; $display("FAIL tmo_start: flush=%b occ=%0d, required 0 5", flush_fifo, fifo_occupancy);
    end
    k = 1;
    while (flush_fifo !== 1'b1 && k < 200) begin
      step(); k++;
    end
    tests++;
    if (flush_fifo !== 1'b1 || k < 100 || k > 102) begin
      fails++; $display("FAIL tmo_rise: flush=%b after %0d cycles, required 1 within 100..102", flush_fifo, k);
    end
    m_axis_tready = 1'b1;
    n = 0;
    for (int g = 0; g < 20 && fifo_occupancy !== 16'd0; g++) begin
      tests++;
      if (flush_fifo !== 1'b1) begin
        fails++; $display("FAIL tmo_hold: got %b, required 1", flush_fifo);
      end
      if (m_axis_tvalid === 1'b1) begin
        tests++;
        if (m_axis_tdata !== 64'h7100 + 64'(n)) begin
          fails++; $display("FAIL tmo_data %0d: got %h, required %h", n, m_axis_tdata, 64'h7100 + 64'(n));
        end
        n++;
      end
      step();
    end
    tests++;
    if (n != 5 || flush_fifo !== 1'b1) begin
      fails++; $display("FAIL tmo_drained: words=%0d flush=%b, required 5 1", n, flush_fifo);
    end
    step();
    tests++;
    if (flush_fifo !== 1'b0) begin
      fails++; $display("FAIL tmo_fall: got %b, required 0", flush_fifo);
    end
    m_axis_tready = 1'b0;
    flush_timeout = 32'd0;
    $display("[TB] timeout_flush: rise after %0d cycles", k);
  endtask

  task automatic test_sw_flush();
    int n;
    m_axis_tready = 1'b0;
    flush_req = 1'b1; step(); flush_req = 1'b0; step();
    tests++;
    if (flush_fifo !== 1'b0) begin
      fails++; $display("FAIL sw_empty_ignored: got %b, required 0", flush_fifo);
    end
    for (int i = 0; i < 3; i++) push(64'h5500 + 64'(i), 1'b0);
    tests++;
    if (fifo_occupancy !== 16'd3 || flush_fifo !== 1'b0) begin
      fails++; $display("FAIL sw_pre: occ=%0d flush=%b, required 3 0", fifo_occupancy, flush_fifo);
    end
    flush_req = 1'b1; step(); flush_req = 1'b0;
    tests++;
    if (flush_fifo !== 1'b1) begin
      fails++; $display("FAIL sw_set: got %b, required 1", flush_fifo);
    end
    for (int i = 0; i < 2; i++) begin
      push(64'h5503 + 64'(i), i == 1);
      tests++;
      if (flush_fifo !== 1'b1) begin
        fails++; $display("FAIL sw_hold_write %0d: got %b, required 1", i, flush_fifo);
      end
    end
    tests++;
    if (fifo_occupancy !== 16'd5) begin
      fails++; $display("FAIL sw_occ: got %0d, required 5", fifo_occupancy);
    end
    m_axis_tready = 1'b1;
    n = 0;
    for (int g = 0; g < 20 && fifo_occupancy !== 16'd0; g++) begin
      if (m_axis_tvalid === 1'b1) begin
        tests++;
        if (m_axis_tdata !== 64'h5500 + 64'(n) || m_axis_tlast !== (n == 4) || flush_fifo !== 1'b1) begin
          fails++;
          $display("FAIL sw_drain %0d: data=%h last=%b flush=%b, required %h %b 1", n,
                   m_axis_tdata, m_axis_tlast, flush_fifo, 64'h5500 + 64'(n), n == 4);
        end
        n++;
      end
      step();
    end
    step();
    tests++;
    if (n != 5 || flush_fifo !== 1'b0) begin
      fails++; $display("FAIL sw_fall: words=%0d flush=%b, required 5 0", n, flush_fifo);
    end
    m_axis_tready = 1'b0;
    $display("[TB] sw_flush: drained %0d words", n);
  endtask

  task automatic test_reset_mid();
    int n;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 40; i++) push(64'h4000 + 64'(i), 1'b0);
    tests++;
    if (fifo_occupancy !== 16'd40) begin
      fails++; $display("FAIL mid_occ40: got %0d, required 40", fifo_occupancy);
    end
    flush_req = 1'b1; step(); flush_req = 1'b0;
    tests++;
    if (flush_fifo !== 1'b1) begin
      fails++; $display("FAIL mid_flush_set: got %b, required 1", flush_fifo);
    end
    m_axis_tready = 1'b1;
    step(); step();
    tests++;
    if (fifo_occupancy !== 16'd38) begin
      fails++; $display("FAIL mid_occ38: got %0d, required 38", fifo_occupancy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (m_axis_tvalid !== 1'b0 || flush_fifo !== 1'b0 || fifo_occupancy !== 16'd0 || s_axis_tready !== 1'b0) begin
      fails++;
      $display("FAIL mid_in_reset: valid=%b flush=%b occ=%0d tready=%b, required 0 0 0 0",
               m_axis_tvalid, flush_fifo, fifo_occupancy, s_axis_tready);
    end
    step();
    rst = 1'b0; m_axis_tready = 1'b0;
    #1;
    tests++;
    if (m_axis_tvalid !== 1'b0 || flush_fifo !== 1'b0 || fifo_occupancy !== 16'd0 ||
        s_axis_tready !== 1'b1 || overflow_count !== 32'd0) begin
      fails++;
      $display("FAIL mid_after_reset: valid=%b flush=%b occ=%0d tready=%b ovf=%0d, required 0 0 0 1 0",
               m_axis_tvalid, flush_fifo, fifo_occupancy, s_axis_tready, overflow_count);
    end
    push(64'hBEEF_0001, 1'b1);
    s_axis_tvalid = 1'b0;
    step();
    tests++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hBEEF_0001 || m_axis_tlast !== 1'b1) begin
      fails++;
      $display("FAIL mid_latency: valid=%b data=%h last=%b, required 1 00000000beef0001 1",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    push(64'hBEEF_0002, 1'b0);
    push(64'hBEEF_0003, 1'b1);
    tests++;
    if (fifo_occupancy !== 16'd3) begin
      fails++; $display("FAIL mid_occ3: got %0d, required 3", fifo_occupancy);
    end
    m_axis_tready = 1'b1;
    n = 0;
    for (int g = 0; g < 10 && fifo_occupancy !== 16'd0; g++) begin
      if (m_axis_tvalid === 1'b1) begin
        tests++;
        if (m_axis_tdata !== 64'hBEEF_0001 + 64'(n)) begin
          fails++; $display("FAIL mid_order %0d: got %h, required %h", n, m_axis_tdata, 64'hBEEF_0001 + 64'(n));
        end
        n++;
      end
      step();
    end
    m_axis_tready = 1'b0;
    tests++;
    if (n != 3 || m_axis_tvalid !== 1'b0) begin
      fails++; $display("FAIL mid_restart_count: words=%0d valid=%b, required 3 0", n, m_axis_tvalid);
    end
    $display("[TB] reset_mid: restarted with %0d words", n);
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_streaming();
    test_timeout_flush();
    test_sw_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
